// File: rtl/weight_load_scheduler.sv
// Weight/bias load sequencer for one conv task: bursts the packed weight stream
// from DDR into the weight buffer and issues one load command per output-channel group.
module weight_load_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DATA_WIDTH  = 512,
  parameter int CNT_WIDTH       = 16,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  system_clk,
  input  logic                  rst,
  input  logic                  task_start,
  input  logic [ADDR_WIDTH-1:0] cfg_weight_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_weight_words,
  input  logic [CNT_WIDTH-1:0]  cfg_group_num,
  input  logic                  cfg_bias_en,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic [7:0]            rd_req_len,
  input  logic                  weight_and_bias_valid,
  input  logic                  weight_buffer_ready,
  input  logic                  weight_and_bias_ready,
  output logic [1:0]            change_weight_bias,
  input  logic                  next_group_req,
  output logic                  next_group_ack,
  output logic                  busy,
  output logic                  task_finish
);

  localparam int BEAT_SHIFT = $clog2(MEM_DATA_WIDTH / 8);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DRAIN, F_DONE} fetch_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT, C_END} cons_state_t;

  fetch_state_t f_state, f_next;
  cons_state_t  c_state, c_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  outstanding_q;
  logic [CNT_WIDTH-1:0]  groups_done_q;
  logic [CNT_WIDTH-1:0]  group_num_q;
  logic [CNT_WIDTH:0]    avail_q;
  logic                  bias_en_q;
  logic                  req_pending_q;

  logic                  start;
  logic                  cfg_zero;
  logic [7:0]            len;
  logic                  fits;
  logic                  req_accept;
  logic                  beat_in;
  logic [CNT_WIDTH:0]    need;
  logic                  issue;
  logic                  last_group;

  assign start      = task_start & ~busy;
  assign cfg_zero   = (cfg_weight_words == '0) || (cfg_group_num == '0);
  assign len        = (remaining_q > CNT_WIDTH'(BURST_LEN)) ? 8'(BURST_LEN) : remaining_q[7:0];
  assign fits       = ({1'b0, outstanding_q} + (CNT_WIDTH+1)'(len)) <= (CNT_WIDTH+1)'(MAX_OUTSTANDING);
  assign beat_in    = busy & weight_and_bias_valid;
  assign need       = bias_en_q ? (CNT_WIDTH+1)'(73) : (CNT_WIDTH+1)'(72);
  assign last_group = (groups_done_q + 1'b1) == group_num_q;

  // A request once raised stays up with stable address/length until accepted,
  // even if buffer space or the outstanding window closes meanwhile.
  assign rd_req_valid = req_pending_q |
                        ((f_state == F_REQ) && weight_buffer_ready && fits);
  assign rd_req_addr  = addr_q;
  assign rd_req_len   = len;
  assign req_accept   = rd_req_valid & rd_req_ready;

  assign issue = (c_state == C_ISSUE) && next_group_req && weight_and_bias_ready &&
                 (avail_q >= need);
  assign change_weight_bias = issue ? (bias_en_q ? 2'b11 : 2'b01) : 2'b00;
  assign next_group_ack     = (c_state == C_WAIT) && weight_and_bias_ready;

  always_comb begin
    f_next = f_state;
    c_next = c_state;
    unique case (f_state)
      F_IDLE:  if (start) f_next = cfg_zero ? F_DONE : F_REQ;
      F_REQ:   if (req_accept && (remaining_q == CNT_WIDTH'(len))) f_next = F_DRAIN;
      F_DRAIN: if (outstanding_q == '0) f_next = F_DONE;
      F_DONE:  f_next = F_DONE;
      default: f_next = F_IDLE;
    endcase
    unique case (c_state)
      C_IDLE:  if (start) c_next = cfg_zero ? C_END : C_ISSUE;
      C_ISSUE: if (issue) c_next = C_WAIT;
      C_WAIT:  if (next_group_ack) c_next = last_group ? C_END : C_ISSUE;
      C_END:   c_next = C_END;
      default: c_next = C_IDLE;
    endcase
    if (task_finish) begin
      f_next = F_IDLE;
      c_next = C_IDLE;
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      f_state <= F_IDLE;
      c_state <= C_IDLE;
    end else begin
      f_state <= f_next;
      c_state <= c_next;
    end
  end

  // Counters and task control; an abort leaves nothing to resume.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      groups_done_q <= '0;
      group_num_q   <= '0;
      avail_q       <= '0;
      bias_en_q     <= 1'b0;
      req_pending_q <= 1'b0;
      busy          <= 1'b0;
      task_finish   <= 1'b0;
    end else begin
      task_finish   <= (f_state == F_DONE) && (c_state == C_END) && !task_finish;
      req_pending_q <= rd_req_valid & ~rd_req_ready;
      if (start) begin
        addr_q        <= cfg_weight_base_addr;
        remaining_q   <= cfg_weight_words;
        outstanding_q <= '0;
        groups_done_q <= '0;
        group_num_q   <= cfg_group_num;
        avail_q       <= '0;
        bias_en_q     <= cfg_bias_en;
        busy          <= 1'b1;
      end else begin
        if (task_finish) busy <= 1'b0;
        if (req_accept) begin
          addr_q      <= addr_q + (ADDR_WIDTH'(len) << BEAT_SHIFT);
          remaining_q <= remaining_q - CNT_WIDTH'(len);
        end
        outstanding_q <= outstanding_q + (req_accept ? CNT_WIDTH'(len) : '0)
                         - ((beat_in && (outstanding_q != '0)) ? CNT_WIDTH'(1) : '0);
        avail_q <= avail_q + (beat_in ? (CNT_WIDTH+1)'(2) : '0) - (issue ? need : '0);
        if (next_group_ack) groups_done_q <= groups_done_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Scoreboard bench for weight_load_scheduler: directed tasks queue expected
// bursts/commands/acks/finishes; a negedge monitor with DDR and buffer models checks them.
module tb_weight_load_scheduler;

  logic        system_clk = 1'b0;
  logic        rst;
  logic        task_start;
  logic [31:0] cfg_weight_base_addr;
  logic [15:0] cfg_weight_words;
  logic [15:0] cfg_group_num;
  logic        cfg_bias_en;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        weight_and_bias_valid;
  logic        weight_buffer_ready;
  logic        weight_and_bias_ready;
  logic [1:0]  change_weight_bias;
  logic        next_group_req;
  logic        next_group_ack;
  logic        busy;
  logic        task_finish;

  weight_load_scheduler dut (
    .system_clk            (system_clk),
    .rst                   (rst),
    .task_start            (task_start),
    .cfg_weight_base_addr  (cfg_weight_base_addr),
    .cfg_weight_words      (cfg_weight_words),
    .cfg_group_num         (cfg_group_num),
    .cfg_bias_en           (cfg_bias_en),
    .rd_req_valid          (rd_req_valid),
    .rd_req_ready          (rd_req_ready),
    .rd_req_addr           (rd_req_addr),
    .rd_req_len            (rd_req_len),
    .weight_and_bias_valid (weight_and_bias_valid),
    .weight_buffer_ready   (weight_buffer_ready),
    .weight_and_bias_ready (weight_and_bias_ready),
    .change_weight_bias    (change_weight_bias),
    .next_group_req        (next_group_req),
    .next_group_ack        (next_group_ack),
    .busy                  (busy),
    .task_finish           (task_finish)
  );

  always #5 system_clk = ~system_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  req_t req_q[$];
  logic [1:0] cmd_q[$];
  int   fin_q[$];
  int   ack_exp = 0;
  int   cyc = 0;
  int   pend = 0;
  int   outst_m = 0;
  int   buf_cnt = 0;
  bit   ddr_en = 1'b1;
  bit   ret_nxt = 1'b0;
  bit   wabr_nxt = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor plus DDR return model and buffer-idle model; decisions are applied after the next posedge.
  always @(negedge system_clk) begin
    if (rst) begin
      pend = 0; outst_m = 0; buf_cnt = 0; ret_nxt = 1'b0; wabr_nxt = 1'b1;
    end else begin
      if (rd_req_valid && rd_req_ready) begin
        if (req_q.size() == 0) unexpected("rd_req");
        else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_addr", 64'(rd_req_addr), 64'(r.addr));
          chk("req_len", 64'(rd_req_len), 64'(r.len));
        end
        pend    += int'(rd_req_len);
        outst_m += int'(rd_req_len);
        chk("outstanding_le_64", 64'(outst_m <= 64), 64'(1));
      end
      if (weight_and_bias_valid) outst_m--;
      ret_nxt = ddr_en && (pend > 0);
      if (ret_nxt) pend--;
      if (change_weight_bias != 2'b00) begin
        if (cmd_q.size() == 0) unexpected("change_weight_bias");
        else chk("cmd_value", 64'(change_weight_bias), 64'(cmd_q.pop_front()));
        chk("cmd_needs_req", 64'(next_group_req), 64'(1));
        buf_cnt  = 3;
        wabr_nxt = 1'b0;
      end else if (buf_cnt > 0) begin
        buf_cnt--;
        if (buf_cnt == 0) wabr_nxt = 1'b1;
      end
      if (next_group_ack) begin
        if (ack_exp == 0) unexpected("next_group_ack");
        else begin
          ack_exp--;
          n_checks++;
        end
      end
      if (task_finish) begin
        if (fin_q.size() == 0) unexpected("task_finish");
        else begin
          int e;
          e = fin_q.pop_front();
          if (e >= 0) chk("finish_cycle", 64'(cyc), 64'(e));
          else n_checks++;
        end
      end
    end
  end

  always @(posedge system_clk) begin
    cyc++;
    #1;
    weight_and_bias_valid = ret_nxt;
    weight_and_bias_ready = wabr_nxt;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge system_clk);
      #1;
    end
  endtask

  task automatic push_bursts(input logic [31:0] base, input int words);
    int rem;
    logic [31:0] a;
    req_t r;
    rem = words;
    a   = base;
    while (rem > 0) begin
      r.addr = a;
      r.len  = 8'((rem > 16) ? 16 : rem);
      req_q.push_back(r);
      a   = a + 32'(int'(r.len) * 64);
      rem = rem - int'(r.len);
    end
  endtask

  task automatic start_task(input logic [31:0] base, input int words, input int groups,
                            input logic bias, input int fin_delay);
    cfg_weight_base_addr = base;
    cfg_weight_words     = 16'(words);
    cfg_group_num        = 16'(groups);
    cfg_bias_en          = bias;
    fin_q.push_back((fin_delay >= 0) ? cyc + fin_delay : -1);
    task_start = 1'b1;
    tick(1);
    task_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int i;
    i = 0;
    while (fin_q.size() != 0 && i < max_cycles) begin
      tick(1);
      i++;
    end
    if (fin_q.size() != 0) begin
      unexpected({name, "_timeout"});
      fin_q.delete();
    end
    chk({name, "_reqs_left"}, 64'(req_q.size()), 64'(0));
    chk({name, "_cmds_left"}, 64'(cmd_q.size()), 64'(0));
    chk({name, "_acks_left"}, 64'(ack_exp), 64'(0));
    chk({name, "_busy_after"}, 64'(busy), 64'(0));
    req_q.delete();
    cmd_q.delete();
    ack_exp = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    task_start = 1'b0;
    cfg_weight_base_addr = '0;
    cfg_weight_words = '0;
    cfg_group_num = '0;
    cfg_bias_en = 1'b0;
    rd_req_ready = 1'b1;
    weight_buffer_ready = 1'b1;
    weight_and_bias_valid = 1'b0;
    weight_and_bias_ready = 1'b1;
    next_group_req = 1'b1;
    tick(2);
    chk("rst_rd_req_valid", 64'(rd_req_valid), 64'(0));
    chk("rst_rd_req_addr", 64'(rd_req_addr), 64'(0));
    chk("rst_rd_req_len", 64'(rd_req_len), 64'(0));
    chk("rst_cmd", 64'(change_weight_bias), 64'(0));
    chk("rst_ack", 64'(next_group_ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_finish", 64'(task_finish), 64'(0));
    rst = 1'b0;
    tick(2);

    // 36 beats, weight only: bursts 16,16,4
    push_bursts(32'h1000_0000, 36);
    cmd_q.push_back(2'b01);
    ack_exp = 1;
    start_task(32'h1000_0000, 36, 1, 1'b0, -1);
    chk("t1_busy", 64'(busy), 64'(1));
    wait_done("t1", 500);

    // bias group held off until the PE array asks
    next_group_req = 1'b0;
    push_bursts(32'h2000_0000, 37);
    start_task(32'h2000_0000, 37, 1, 1'b1, -1);
    tick(150);
    chk("t2_no_cmd_yet", 64'(change_weight_bias), 64'(0));
    chk("t2_still_busy", 64'(busy), 64'(1));
    chk("t2_all_fetched", 64'(req_q.size()), 64'(0));
    cmd_q.push_back(2'b11);
    ack_exp = 1;
    next_group_req = 1'b1;
    wait_done("t2", 200);

    // outstanding window and buffer back-pressure
    ddr_en = 1'b0;
    push_bursts(32'h3000_0000, 200);
    cmd_q.push_back(2'b01);
    ack_exp = 1;
    start_task(32'h3000_0000, 200, 1, 1'b0, -1);
    tick(20);
    chk("t3_stalled_at_window", 64'(rd_req_valid), 64'(0));
    chk("t3_bursts_before_stall", 64'(req_q.size()), 64'(9));
    weight_buffer_ready = 1'b0;
    ddr_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("t3_no_req_when_full", 64'(rd_req_valid), 64'(0));
    end
    weight_buffer_ready = 1'b1;
    wait_done("t3", 1000);

    // zero groups: no traffic, finish two cycles after start
    start_task(32'h4000_0000, 36, 0, 1'b0, 2);
    wait_done("t4", 20);

    // abort mid-burst, then restart from base
    rd_req_ready = 1'b0;
    start_task(32'h5000_0000, 36, 1, 1'b0, -1);
    tick(3);
    chk("t5_req_held", 64'(rd_req_valid), 64'(1));
    chk("t5_req_addr_held", 64'(rd_req_addr), 64'(32'h5000_0000));
    chk("t5_req_len_held", 64'(rd_req_len), 64'(16));
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(rd_req_valid), 64'(0));
    chk("t5_rst_addr", 64'(rd_req_addr), 64'(0));
    chk("t5_rst_len", 64'(rd_req_len), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_cmd", 64'(change_weight_bias), 64'(0));
    fin_q.delete();
    tick(1);
    rst = 1'b0;
    rd_req_ready = 1'b1;
    tick(1);
    push_bursts(32'h5000_0000, 36);
    cmd_q.push_back(2'b01);
    ack_exp = 1;
    start_task(32'h5000_0000, 36, 1, 1'b0, -1);
    wait_done("t5", 500);

    // two groups from exactly 144 half-words: the return beat landing on the
    // first issue cycle must still be credited
    push_bursts(32'h6000_0000, 72);
    cmd_q.push_back(2'b01);
    cmd_q.push_back(2'b01);
    ack_exp = 2;
    start_task(32'h6000_0000, 72, 2, 1'b0, -1);
    wait_done("t6", 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
